// File: rtl/alu_pipe_pkg.sv
// rtl/alu_pipe_pkg.sv - opcode constants and flag bundle shared by the ALU pipeline
package alu_pipe_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB   = 3'd1;
    localparam logic [OP_W-1:0] OP_INC   = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC   = 3'd3;
    localparam logic [OP_W-1:0] OP_CMP   = 3'd4;
    localparam logic [OP_W-1:0] OP_MIN   = 3'd5;
    localparam logic [OP_W-1:0] OP_MAX   = 3'd6;
    localparam logic [OP_W-1:0] OP_CSWAP = 3'd7;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
        logic carry;
        logic ovf;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/alu_pipe_core.sv
// rtl/alu_pipe_core.sv - combinational ALU for stage 2; ALU_SAT_EN selects saturating ADD/SUB/INC/DEC
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SIGNED = 0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] res,
    output logic [DATA_W-1:0] res_2,
    output alu_flags_t        flags
);

    localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    logic              is_add;
    logic              is_sub;
    logic [DATA_W-1:0] rhs;
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W:0]   arith;
    logic              ovf_raw;
    logic              lt;
    logic              eq;
    logic              gt;

    assign is_add = (op == OP_ADD) || (op == OP_INC);
    assign is_sub = (op == OP_SUB) || (op == OP_DEC);
    assign rhs    = ((op == OP_INC) || (op == OP_DEC)) ? ONE : b;
    assign sum    = {1'b0, a} + {1'b0, rhs};
    // Bit DATA_W of the widened difference is the unsigned borrow (a < rhs).
    assign diff   = {1'b0, a} - {1'b0, rhs};
    assign arith  = is_sub ? diff : sum;

    assign ovf_raw = (SIGNED != 0)
                   && ((is_add && (a[DATA_W-1] == rhs[DATA_W-1]))
                    || (is_sub && (a[DATA_W-1] != rhs[DATA_W-1])))
                   && (arith[DATA_W-1] != a[DATA_W-1]);

    assign eq = (a == b);
    assign lt = (SIGNED != 0) ? ($signed(a) < $signed(b)) : (a < b);
    assign gt = !lt && !eq;

`ifdef ALU_SAT_EN
    logic [DATA_W-1:0] sat_val;
    logic              sat_hit;

    // Signed overflow direction follows the sign of a; unsigned depends on add vs sub.
    assign sat_val = (SIGNED != 0)
                   ? (a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}})
                   : (is_add ? {DATA_W{1'b1}} : {DATA_W{1'b0}});
    assign sat_hit = (SIGNED != 0) ? ovf_raw : arith[DATA_W];
`endif

    always_comb begin
        res   = '0;
        res_2 = '0;
        flags = '0;
        case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                res         = arith[DATA_W-1:0];
                flags.carry = arith[DATA_W];
                flags.ovf   = ovf_raw;
`ifdef ALU_SAT_EN
                if (sat_hit) res = sat_val;
`endif
            end
            OP_CMP: begin
                flags.lt = lt;
                flags.eq = eq;
                flags.gt = gt;
            end
            OP_MIN, OP_MAX, OP_CSWAP: begin
                flags.lt = lt;
                flags.eq = eq;
                flags.gt = gt;
                if (op == OP_MAX) res = lt ? b : a;
                else              res = gt ? b : a;
                if (op == OP_CSWAP) res_2 = lt ? b : a;
            end
            default: res = '0;
        endcase
        flags.zero = (res == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline; ALU_SAT_EN (in core) enables saturation
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [OP_W-1:0]   op_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] out_data_2,
    output logic              a_lt_b,
    output logic              a_eq_b,
    output logic              a_gt_b,
    output logic              carry,
    output logic              ovf,
    output logic              zero
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [OP_W-1:0]   s1_op;
    logic              en1;
    logic              en2;
    logic [DATA_W-1:0] core_res;
    logic [DATA_W-1:0] core_res_2;
    alu_flags_t        core_flags;
    alu_flags_t        out_flags;

    assign en2      = !out_valid || out_ready;
    assign en1      = !s1_valid || en2;
    assign in_ready = en1;

    alu_pipe_core #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .op    (s1_op),
        .res   (core_res),
        .res_2 (core_res_2),
        .flags (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_data_2 <= '0;
            out_flags  <= '0;
        end else begin
            if (en1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_op <= op_sel;
                end
            end
            // Output registers only move when the consumer can take a new result.
            if (en2) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data   <= core_res;
                    out_data_2 <= core_res_2;
                    out_flags  <= core_flags;
                end
            end
        end
    end

    assign a_lt_b = out_flags.lt;
    assign a_eq_b = out_flags.eq;
    assign a_gt_b = out_flags.gt;
    assign carry  = out_flags.carry;
    assign ovf    = out_flags.ovf;
    assign zero   = out_flags.zero;

endmodule
